// File: rtl/dcache_wb.sv
// dcache_wb: direct-mapped, write-back, write-allocate data cache.
// Processor side: word-addressed ren/wen requests. proc_stall stays high
// until the access completes. Hits complete in the request cycle.
// Memory side: 128-bit block read/write port completed by a one-cycle mem_ready pulse.
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   proc_ren/proc_wen    read / write request (both high acts as a write)
//   proc_addr[29:0]      word address {tag, index, offset}
//   proc_wdata[31:0]     write data
//   proc_rdata[31:0]     read data, valid with proc_ren=1 and proc_stall=0
//   proc_stall           request not yet complete
//   mem_read/mem_write   block read / write-back request
//   mem_addr[27:0]       block address
//   mem_wdata[127:0]     write-back block, word0 in [31:0]
//   mem_rdata[127:0]     refill block, word0 in [31:0]
//   mem_ready            memory completed the current transaction
module dcache_wb #(
  parameter int unsigned NUM_LINES = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         proc_ren,
  input  logic         proc_wen,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic [31:0]  proc_rdata,
  output logic         proc_stall,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);

  localparam int unsigned IW = $clog2(NUM_LINES);
  localparam int unsigned TW = 28 - IW;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [NUM_LINES-1:0] valid, dirty;
  logic [TW-1:0]        tag_arr  [NUM_LINES];
  logic [127:0]         data_arr [NUM_LINES];

  // Block address captured when a miss is detected; drives the whole miss
  // sequence so memory-side outputs stay stable regardless of processor inputs.
  logic [27:0] miss_blk;

  logic          req;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic [1:0]    off;
  logic [IW-1:0] miss_idx;
  logic          hit;
  logic [127:0]  merged_line;

  assign req      = proc_ren | proc_wen;
  assign idx      = proc_addr[IW+1:2];
  assign tag      = proc_addr[29:IW+2];
  assign off      = proc_addr[1:0];
  assign miss_idx = miss_blk[IW-1:0];
  assign hit      = valid[idx] && (tag_arr[idx] == tag);

  // Current line with the addressed word replaced by the write data.
  always_comb begin
    merged_line = data_arr[idx];
    merged_line[{off, 5'd0} +: 32] = proc_wdata;
  end

  // Processor-side handshake and read data (combinational for 0-cycle hits).
  always_comb begin
    proc_stall = 1'b0;
    proc_rdata = 32'd0;
    if (req && !((state == IDLE) && hit)) begin
      proc_stall = 1'b1;
    end
    if ((state == IDLE) && hit && proc_ren) begin
      proc_rdata = data_arr[idx][{off, 5'd0} +: 32];
    end
  end

  // Next-state logic and memory-side outputs decoded from registered state.
  always_comb begin
    state_next = state;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = 28'd0;
    mem_wdata  = 128'd0;
    case (state)
      IDLE: begin
        if (req && !hit) begin
          state_next = (valid[idx] && dirty[idx]) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        mem_write = 1'b1;
        mem_addr  = {tag_arr[miss_idx], miss_idx};
        mem_wdata = data_arr[miss_idx];
        if (mem_ready) begin
          state_next = ALLOCATE;
        end
      end
      ALLOCATE: begin
        mem_read = 1'b1;
        mem_addr = miss_blk;
        if (mem_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register and line storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      valid    <= '0;
      dirty    <= '0;
      miss_blk <= 28'd0;
      for (int unsigned i = 0; i < NUM_LINES; i++) begin
        tag_arr[i]  <= '0;
        data_arr[i] <= '0;
      end
    end else begin
      state <= state_next;
      if ((state == IDLE) && req && !hit) begin
        miss_blk <= proc_addr[29:2];
      end
      if ((state == IDLE) && proc_wen && hit) begin
        data_arr[idx] <= merged_line;
        dirty[idx]    <= 1'b1;
      end
      if ((state == ALLOCATE) && mem_ready) begin
        data_arr[miss_idx] <= mem_rdata;
        tag_arr[miss_idx]  <= miss_blk[27:IW];
        valid[miss_idx]    <= 1'b1;
        dirty[miss_idx]    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dcache_wb.sv
// Directed bench for dcache_wb: memory responder with a configurable latency,
// shadow word store for expected read data, and scoreboards for reads and
// memory transactions.
module tb_dcache_wb;

  logic         clk = 1'b0;
  logic         rst;
  logic         proc_ren, proc_wen;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  dcache_wb #(.NUM_LINES(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .proc_ren   (proc_ren),
    .proc_wen   (proc_wen),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_rdata (proc_rdata),
    .proc_stall (proc_stall),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         wr;
    logic [27:0]  addr;
    logic [127:0] data;
  } txn_t;

  int errors = 0;
  int checks = 0;
  int lat    = 3;
  int cnt    = 0;

  logic [127:0] mem    [logic [27:0]];
  logic [31:0]  shadow [logic [29:0]];
  txn_t         log_q[$];
  txn_t         exp_txn_q[$];
  logic [31:0]  exp_rd_q[$];

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] blk(input logic [27:0] a);
    if (mem.exists(a)) return mem[a];
    return {4'h3, a, 4'h2, a, 4'h1, a, 4'h0, a};
  endfunction

  function automatic logic [31:0] exp_word(input logic [29:0] a);
    logic [127:0] b;
    if (shadow.exists(a)) return shadow[a];
    b = blk(a[29:2]);
    return b[32*a[1:0] +: 32];
  endfunction

  function automatic logic [127:0] line_of(input logic [27:0] b);
    logic [127:0] l;
    for (int i = 0; i < 4; i++) l[32*i +: 32] = exp_word({b, 2'(i)});
    return l;
  endfunction

  // Memory responder: pulses mem_ready after lat cycles of an active request.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = 128'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mem_ready = 1'b0;
        cnt = 0;
      end else begin
        if (mem_ready) begin
          mem_ready = 1'b0;
          cnt = 0;
        end
        if (mem_read || mem_write) begin
          cnt++;
          if (cnt == lat) begin
            mem_ready = 1'b1;
            if (mem_write) begin
              log_q.push_back({1'b1, mem_addr, mem_wdata});
              mem[mem_addr] = mem_wdata;
            end else begin
              mem_rdata = blk(mem_addr);
              log_q.push_back({1'b0, mem_addr, 128'd0});
            end
          end
        end
      end
    end
  end

  task automatic check_txns(input string tag);
    txn_t o, e;
    chk({tag, "_ntxn"}, 160'(log_q.size()), 160'(exp_txn_q.size()));
    while (log_q.size() > 0 && exp_txn_q.size() > 0) begin
      o = log_q.pop_front();
      e = exp_txn_q.pop_front();
      chk({tag, "_txn"}, 160'(o), 160'(e));
    end
    log_q.delete();
    exp_txn_q.delete();
  endtask

  task automatic access(input logic r, input logic w, input logic [29:0] a,
                        input logic [31:0] wd, input int exp_stall, input string tag);
    int n = 0;
    @(negedge clk);
    proc_ren = r; proc_wen = w; proc_addr = a; proc_wdata = wd;
    if (w) shadow[a] = wd;
    else   exp_rd_q.push_back(exp_word(a));
    #1;
    chk({tag, "_stall0"}, 160'(proc_stall), 160'(exp_stall > 0));
    while (proc_stall && n < 200) begin
      chk({tag, "_mutex"}, 160'(mem_read & mem_write), 160'(0));
      n++;
      @(negedge clk);
      #1;
    end
    chk({tag, "_cycles"}, 160'(n), 160'(exp_stall));
    if (!w) chk({tag, "_rdata"}, 160'(proc_rdata), 160'(exp_rd_q.pop_front()));
    check_txns(tag);
  endtask

  initial begin
    rst = 1'b1;
    proc_ren = 1'b0; proc_wen = 1'b0; proc_addr = 30'd0; proc_wdata = 32'd0;
    mem[28'h4] = {32'hD, 32'hC, 32'hB, 32'hA};
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", 160'(proc_stall), 160'(0));
    chk("rst_rdata", 160'(proc_rdata), 160'(0));
    chk("rst_mread", 160'(mem_read), 160'(0));
    chk("rst_mwrite", 160'(mem_write), 160'(0));
    chk("rst_maddr", 160'(mem_addr), 160'(0));
    chk("rst_mwdata", 160'(mem_wdata), 160'(0));
    rst = 1'b0;

    // Clean read miss, then a hit in the same line.
    exp_txn_q.push_back({1'b0, 28'h4, 128'd0});
    access(1'b1, 1'b0, 30'h10, 32'd0, lat + 1, "rd_miss");
    access(1'b1, 1'b0, 30'h13, 32'd0, 0, "rd_hit3");

    // Write hit then read back.
    access(1'b0, 1'b1, 30'h11, 32'h12345678, 0, "wr_hit");
    access(1'b1, 1'b0, 30'h11, 32'd0, 0, "rd_wr");

    // Conflict on dirty line: write-back then allocate.
    exp_txn_q.push_back({1'b1, 28'h4, {32'hD, 32'hC, 32'h12345678, 32'hA}});
    exp_txn_q.push_back({1'b0, 28'hC, 128'd0});
    access(1'b1, 1'b0, 30'h30, 32'd0, 2 * lat + 1, "conflict");

    // Write miss to an invalid line: allocate only, word merged.
    exp_txn_q.push_back({1'b0, 28'h11, 128'd0});
    access(1'b0, 1'b1, 30'h44, 32'hCAFEF00D, lat + 1, "wr_miss");
    for (int i = 0; i < 4; i++) access(1'b1, 1'b0, 30'h44 + 30'(i), 32'd0, 0, "wm_rd");

    // Evicting the write-miss line proves it was dirty with the merged data.
    exp_txn_q.push_back({1'b1, 28'h11, line_of(28'h11)});
    exp_txn_q.push_back({1'b0, 28'h21, 128'd0});
    access(1'b1, 1'b0, 30'h84, 32'd0, 2 * lat + 1, "wm_evict");

    // Reset during ALLOCATE.
    lat = 5;
    @(negedge clk);
    proc_ren = 1'b1; proc_wen = 1'b0; proc_addr = 30'h104;
    repeat (3) @(negedge clk);
    #1;
    chk("abort_mread_hi", 160'(mem_read), 160'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("abort_mread", 160'(mem_read), 160'(0));
    chk("abort_mwrite", 160'(mem_write), 160'(0));
    proc_ren = 1'b0;
    #1;
    chk("abort_stall", 160'(proc_stall), 160'(0));
    @(negedge clk);
    #1;
    rst = 1'b0;
    log_q.delete();
    exp_txn_q.delete();
    lat = 3;

    // Previously filled line was cleared by reset: must miss again.
    exp_txn_q.push_back({1'b0, 28'h21, 128'd0});
    access(1'b1, 1'b0, 30'h84, 32'd0, lat + 1, "reread");

    // ren and wen together act as a write with no memory traffic.
    access(1'b1, 1'b1, 30'h84, 32'h00000055, 0, "renwen");
    access(1'b1, 1'b0, 30'h84, 32'd0, 0, "renwen_rd");
    access(1'b1, 1'b0, 30'h85, 32'd0, 0, "renwen_rd1");

    @(negedge clk);
    proc_ren = 1'b0; proc_wen = 1'b0;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
